// File: rtl/grant_dispatch.sv
// Index FIFO feeding a one-hot grant FSM (IDLE -> GRANT -> RELEASE).
// Define GRANT_DISPATCH_TIMEOUT_EN to let an unacknowledged grant expire after TIMEOUT cycles.
module grant_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               idx_in,
  input  logic                     idx_valid,
  output logic                     idx_ready,
  output logic [3:0]               grant,
  input  logic                     grant_ack,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [1:0]     cur_idx;
  logic           push, pop, expire;

  // Ready depends only on registered occupancy, never on idx_valid.
  assign idx_ready = (level != (AW+1)'(DEPTH));
  assign push      = idx_valid && idx_ready;
  assign pop       = (state == IDLE) && (level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= idx_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cur_idx <= '0;
    else if (pop)
      cur_idx <= mem[rd_ptr];
  end

`ifdef GRANT_DISPATCH_TIMEOUT_EN
  logic [7:0] cnt;

  // Ack on the expiry cycle wins, so no pulse is raised then.
  assign expire = (state == GRANT) && (cnt == 8'(TIMEOUT - 1)) && !grant_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (state == GRANT)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = GRANT;
      GRANT:   if (grant_ack || expire) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant = 4'b0000;
    if (state == GRANT)
      grant = 4'b0001 << cur_idx;
  end

endmodule
